// File: rtl/tinyqv_mem_pkg.sv
// Shared encodings and helpers for the TinyQV memory arbiter.
package tinyqv_mem_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INSTR = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_INSTR = ST_INSTR,
        S_DATA  = ST_DATA,
        S_RESP  = ST_RESP
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Width needed to hold a burst count that saturates at max_burst.
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/tinyqv_mem_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and load/store,
// with data priority bounded by a burst limit and flush-aware fetch completion.
module tinyqv_mem_arbiter
    import tinyqv_mem_pkg::*;
#(
    parameter int ADDR_W     = 28,
    parameter int PC_W       = 24,
    parameter int MAX_DBURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_req,
    input  logic [PC_W-1:0]   instr_addr,
    input  logic              instr_flush,
    output logic [31:0]       instr_data,
    output logic              instr_ready,
    input  logic              data_rd_req,
    input  logic              data_wr_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_ready,
    output logic              mem_start,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_done
);

    localparam int CNT_W = burst_cnt_w(MAX_DBURST);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DBURST);

    state_t            state_q,       state_d;
    logic [CNT_W-1:0]  burst_q,       burst_d;
    logic              discard_q,     discard_d;
    logic              mem_start_q,   mem_start_d;
    logic              mem_write_q,   mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [1:0]        mem_size_q,    mem_size_d;
    logic [31:0]       mem_wdata_q,   mem_wdata_d;
    logic [31:0]       instr_data_q,  instr_data_d;
    logic              instr_ready_q, instr_ready_d;
    logic [31:0]       data_rdata_q,  data_rdata_d;
    logic              data_ready_q,  data_ready_d;
    logic              data_req;

    function automatic logic [CNT_W-1:0] burst_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= BURST_MAX) ? BURST_MAX : cnt + CNT_W'(1);
    endfunction

    assign data_req = data_rd_req | data_wr_req;

    always_comb begin
        state_d       = state_q;
        burst_d       = burst_q;
        discard_d     = discard_q;
        mem_start_d   = 1'b0;
        mem_write_d   = mem_write_q;
        mem_addr_d    = mem_addr_q;
        mem_size_d    = mem_size_q;
        mem_wdata_d   = mem_wdata_q;
        instr_data_d  = instr_data_q;
        instr_ready_d = 1'b0;
        data_rdata_d  = data_rdata_q;
        data_ready_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (data_req && (burst_q < BURST_MAX || !instr_req)) begin
                    state_d     = S_DATA;
                    mem_start_d = 1'b1;
                    mem_write_d = data_wr_req;
                    mem_addr_d  = data_addr;
                    mem_size_d  = data_size;
                    mem_wdata_d = data_wdata;
                    // The burst only counts grants that actually kept fetch waiting.
                    burst_d     = instr_req ? burst_inc(burst_q) : '0;
                end else if (instr_req && !instr_flush) begin
                    state_d     = S_INSTR;
                    mem_start_d = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = ADDR_W'(instr_addr);
                    mem_size_d  = SIZE_WORD;
                    burst_d     = '0;
                    discard_d   = 1'b0;
                end
            end
            S_INSTR: begin
                if (instr_flush) begin
                    discard_d = 1'b1;
                end
                if (mem_done) begin
                    state_d       = S_RESP;
                    instr_ready_d = !(discard_q || instr_flush);
                    instr_data_d  = mem_rdata;
                end
            end
            S_DATA: begin
                if (mem_done) begin
                    state_d      = S_RESP;
                    data_ready_d = 1'b1;
                    if (!mem_write_q) begin
                        data_rdata_d = mem_rdata;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            burst_q       <= '0;
            discard_q     <= 1'b0;
            mem_start_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_size_q    <= '0;
            mem_wdata_q   <= '0;
            instr_data_q  <= '0;
            instr_ready_q <= 1'b0;
            data_rdata_q  <= '0;
            data_ready_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_q       <= burst_d;
            discard_q     <= discard_d;
            mem_start_q   <= mem_start_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_size_q    <= mem_size_d;
            mem_wdata_q   <= mem_wdata_d;
            instr_data_q  <= instr_data_d;
            instr_ready_q <= instr_ready_d;
            data_rdata_q  <= data_rdata_d;
            data_ready_q  <= data_ready_d;
        end
    end

    assign instr_data  = instr_data_q;
    assign instr_ready = instr_ready_q;
    assign data_rdata  = data_rdata_q;
    assign data_ready  = data_ready_q;
    assign mem_start   = mem_start_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_size    = mem_size_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Directed bench for tinyqv_mem_arbiter: fetch, load, store, burst limit, flush and reset cases.
module tb_tinyqv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [23:0] instr_addr;
    logic        instr_flush;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic        data_rd_req;
    logic        data_wr_req;
    logic [27:0] data_addr;
    logic [1:0]  data_size;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        mem_start;
    logic        mem_write;
    logic [27:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] burst_exp [0:5];

    tinyqv_mem_arbiter #(.ADDR_W(28), .PC_W(24), .MAX_DBURST(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_flush (instr_flush),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .data_rd_req (data_rd_req),
        .data_wr_req (data_wr_req),
        .data_addr   (data_addr),
        .data_size   (data_size),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_ready  (data_ready),
        .mem_start   (mem_start),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_size    (mem_size),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!mem_start && n < 8);
        chk({tag, "_start"}, {31'b0, mem_start}, 32'd1);
    endtask

    task automatic do_done(input logic [31:0] rdata);
        mem_done  = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_done  = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_start"},   {31'b0, mem_start},   32'd0);
        chk({tag, "_mem_write"},   {31'b0, mem_write},   32'd0);
        chk({tag, "_mem_addr"},    {4'b0, mem_addr},     32'd0);
        chk({tag, "_mem_size"},    {30'b0, mem_size},    32'd0);
        chk({tag, "_mem_wdata"},   mem_wdata,            32'd0);
        chk({tag, "_instr_ready"}, {31'b0, instr_ready}, 32'd0);
        chk({tag, "_instr_data"},  instr_data,           32'd0);
        chk({tag, "_data_ready"},  {31'b0, data_ready},  32'd0);
        chk({tag, "_data_rdata"},  data_rdata,           32'd0);
    endtask

    initial begin
        rst = 1'b1;
        instr_req = 1'b0; instr_addr = '0; instr_flush = 1'b0;
        data_rd_req = 1'b0; data_wr_req = 1'b0; data_addr = '0;
        data_size = '0; data_wdata = '0; mem_rdata = '0; mem_done = 1'b0;
        ticks(2);
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_no_start", {31'b0, mem_start}, 32'd0);

        // Fetch only, memory answers 4 cycles after mem_start
        instr_req = 1'b1; instr_addr = 24'h000100;
        wait_start("t1");
        chk("t1_addr",  {4'b0, mem_addr},   32'h0000100);
        chk("t1_size",  {30'b0, mem_size},  32'h2);
        chk("t1_write", {31'b0, mem_write}, 32'd0);
        ticks(4);
        chk("t1_start_pulse", {31'b0, mem_start}, 32'd0);
        chk("t1_addr_held",   {4'b0, mem_addr},   32'h0000100);
        chk("t1_no_early_rdy", {31'b0, instr_ready}, 32'd0);
        do_done(32'h00000013);
        instr_req = 1'b0;
        chk("t1_ready", {31'b0, instr_ready}, 32'd1);
        chk("t1_data",  instr_data,           32'h00000013);
        tick();
        chk("t1_ready_pulse", {31'b0, instr_ready}, 32'd0);

        // Fetch and load together: load first, then the fetch
        instr_req = 1'b1; instr_addr = 24'h000104;
        data_rd_req = 1'b1; data_addr = 28'h1000004; data_size = 2'b10;
        wait_start("t2d");
        chk("t2_daddr",  {4'b0, mem_addr},   32'h1000004);
        chk("t2_dwrite", {31'b0, mem_write}, 32'd0);
        tick();
        do_done(32'hDEADBEEF);
        data_rd_req = 1'b0;
        chk("t2_dready", {31'b0, data_ready},  32'd1);
        chk("t2_drdata", data_rdata,           32'hDEADBEEF);
        chk("t2_no_irdy", {31'b0, instr_ready}, 32'd0);
        wait_start("t2i");
        chk("t2_iaddr", {4'b0, mem_addr},  32'h0000104);
        chk("t2_isize", {30'b0, mem_size}, 32'h2);
        do_done(32'h11111111);
        instr_req = 1'b0;
        chk("t2_iready", {31'b0, instr_ready}, 32'd1);
        chk("t2_idata",  instr_data,           32'h11111111);
        chk("t2_no_drdy", {31'b0, data_ready}, 32'd0);
        tick();

        // Byte store; request fields change after grant to prove latching
        data_wr_req = 1'b1; data_addr = 28'h1000010; data_size = 2'b00; data_wdata = 32'h000000AB;
        wait_start("t3");
        data_addr = 28'h0; data_wdata = 32'h0; data_size = 2'b10;
        ticks(2);
        chk("t3_write", {31'b0, mem_write}, 32'd1);
        chk("t3_wdata", mem_wdata,          32'h000000AB);
        chk("t3_addr",  {4'b0, mem_addr},   32'h1000010);
        chk("t3_size",  {30'b0, mem_size},  32'h0);
        do_done(32'h12345678);
        data_wr_req = 1'b0;
        chk("t3_dready",   {31'b0, data_ready},  32'd1);
        chk("t3_rdata_kept", data_rdata,         32'hDEADBEEF);
        chk("t3_no_irdy",  {31'b0, instr_ready}, 32'd0);
        tick();

        // Burst limit: D,D,D,D,I,D
        burst_exp[0] = 32'h1000020; burst_exp[1] = 32'h1000020;
        burst_exp[2] = 32'h1000020; burst_exp[3] = 32'h1000020;
        burst_exp[4] = 32'h0000300; burst_exp[5] = 32'h1000020;
        instr_req = 1'b1; instr_addr = 24'h000300;
        data_rd_req = 1'b1; data_addr = 28'h1000020; data_size = 2'b10;
        for (int g = 0; g < 6; g++) begin
            wait_start($sformatf("t4_g%0d", g));
            chk($sformatf("t4_addr_g%0d", g), {4'b0, mem_addr}, burst_exp[g]);
            do_done(32'h40 + g);
        end
        instr_req = 1'b0; data_rd_req = 1'b0;
        ticks(2);

        // Flush one cycle after mem_start of a fetch, then refetch at the target
        instr_req = 1'b1; instr_addr = 24'h000400;
        wait_start("t5a");
        chk("t5_addr_a", {4'b0, mem_addr}, 32'h0000400);
        tick();
        instr_flush = 1'b1; instr_addr = 24'h000200;
        tick();
        instr_flush = 1'b0;
        tick();
        do_done(32'h00000099);
        chk("t5_discard", {31'b0, instr_ready}, 32'd0);
        tick();
        instr_flush = 1'b1;
        tick();
        chk("t5_idle_flush_blocks", {31'b0, mem_start}, 32'd0);
        instr_flush = 1'b0;
        wait_start("t5b");
        chk("t5_addr_b", {4'b0, mem_addr}, 32'h0000200);
        do_done(32'h00000077);
        instr_req = 1'b0;
        chk("t5_ready_b", {31'b0, instr_ready}, 32'd1);
        chk("t5_data_b",  instr_data,           32'h00000077);
        tick();

        // Reset during a load before mem_done
        data_rd_req = 1'b1; data_addr = 28'h1000030; data_size = 2'b01;
        wait_start("t6a");
        chk("t6_addr_a", {4'b0, mem_addr}, 32'h1000030);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; data_rd_req = 1'b0;
        chk_all_zero("t6_rst");
        do_done(32'h00000BAD);
        chk("t6_late_done_dready", {31'b0, data_ready},  32'd0);
        chk("t6_late_done_irdy",   {31'b0, instr_ready}, 32'd0);
        chk("t6_late_done_start",  {31'b0, mem_start},   32'd0);
        chk("t6_late_done_rdata",  data_rdata,           32'd0);
        data_rd_req = 1'b1; data_addr = 28'h1000040; data_size = 2'b10;
        wait_start("t6b");
        chk("t6_addr_b", {4'b0, mem_addr}, 32'h1000040);
        do_done(32'hCAFEF00D);
        data_rd_req = 1'b0;
        chk("t6_dready_b", {31'b0, data_ready}, 32'd1);
        chk("t6_rdata_b",  data_rdata,          32'hCAFEF00D);
        tick();
        chk("t6_dready_pulse", {31'b0, data_ready}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
